// File: rtl/ad9866_pkg.sv
// Shared constants and types for the AD9866 serial-control responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ad9866_pkg;

    localparam int unsigned AD9866_FRAME_BITS   = 16;
    localparam int unsigned AD9866_NUM_REGS_DEF = 20;

    localparam logic [4:0] AD9866_REG_RXGAIN = 5'h09;
    localparam logic [4:0] AD9866_REG_TXGAIN = 5'h0a;

    // Power-on contents: reg 0x00 selects 4-wire SPI, everything else clear.
    localparam logic [7:0] AD9866_RST_VALS [AD9866_NUM_REGS_DEF] = '{0: 8'h80, default: 8'h00};

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        SHIFT     = 3'd2,
        COMMIT    = 3'd3,
        DONE      = 3'd4
    } resp_state_t;

    // On-wire frame layout, MSB first.
    typedef struct packed {
        logic       rw;        // 1 = read
        logic [1:0] byte_cnt;  // only 00 (single byte) is accepted
        logic [4:0] addr;
        logic [7:0] data;
    } frame_t;

    function automatic logic [7:0] ad9866_rst_val(input int unsigned idx);
        if (idx < AD9866_NUM_REGS_DEF) begin
            return AD9866_RST_VALS[idx[4:0]];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizes sclk/sen_n/sdio into clk and flags sclk/sen_n edges.
// Latency: SYNC_STAGES clk to the synchronized levels, edges flagged in that same cycle.
// Backpressure: none; free-running sampler.
//
// Ports: clk, rst_n; raw sclk/sen_n/sdio in; synchronized sen_n_s/sdio_s and
// single-cycle sclk_rise/sclk_fall/sen_rise/sen_fall out.
module spi_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic sen_n,
    input  logic sdio,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic sen_n_s,
    output logic sen_rise,
    output logic sen_fall,
    output logic sdio_s
);

    logic sclk_s;
    logic sclk_q;
    logic sen_n_q;

    // sdio goes through the same depth as sclk so the bit sampled on a
    // detected rising edge is the one present at the raw edge.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sclk_s  = sclk;
            assign sen_n_s = sen_n;
            assign sdio_s  = sdio;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sclk_ff;
            logic [SYNC_STAGES-1:0] sen_ff;
            logic [SYNC_STAGES-1:0] sdio_ff;

            // sen_n chain resets to "enabled" so the responder cannot mistake
            // the reset value for an idle bus while the chain refills.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sclk_ff <= '0;
                    sen_ff  <= '0;
                    sdio_ff <= '0;
                end else begin
                    sclk_ff[0] <= sclk;
                    sen_ff[0]  <= sen_n;
                    sdio_ff[0] <= sdio;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sclk_ff[i] <= sclk_ff[i-1];
                        sen_ff[i]  <= sen_ff[i-1];
                        sdio_ff[i] <= sdio_ff[i-1];
                    end
                end
            end

            assign sclk_s  = sclk_ff[SYNC_STAGES-1];
            assign sen_n_s = sen_ff[SYNC_STAGES-1];
            assign sdio_s  = sdio_ff[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q  <= 1'b0;
            sen_n_q <= 1'b0;
        end else begin
            sclk_q  <= sclk_s;
            sen_n_q <= sen_n_s;
        end
    end

    assign sclk_rise = ~sclk_q & sclk_s;
    assign sclk_fall = sclk_q & ~sclk_s;
    assign sen_rise  = ~sen_n_q & sen_n_s;
    assign sen_fall  = sen_n_q & ~sen_n_s;

endmodule

// File: rtl/ad9866_spi_responder.sv
// AD9866 serial-control slave model: decodes 16-bit frames into a register file.
// Latency: write commits 1 clk after the 16th detected sclk rise; host_data 1 clk.
// Backpressure: none; frames are accepted at line rate, malformed ones flag frame_err.
//
// Ports: clk, rst_n; SPI spi_sclk/spi_sen_n/spi_sdio in, spi_sdo out;
// wr_strobe/wr_addr/wr_data commit report; tx_gain/rx_gain register views;
// frame_err pulse; host_addr in / host_data out local read port.
// Build option: define AD9866_RESP_READBACK_EN to implement read frames on spi_sdo.
module ad9866_spi_responder
    import ad9866_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_REGS    = AD9866_NUM_REGS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sclk,
    input  logic       spi_sen_n,
    input  logic       spi_sdio,
    output logic       spi_sdo,
    output logic       wr_strobe,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [3:0] tx_gain,
    output logic [5:0] rx_gain,
    output logic       frame_err,
    input  logic [4:0] host_addr,
    output logic [7:0] host_data
);

    logic sclk_rise;
    logic sen_n_s;
    logic sen_rise;
    logic sen_fall;
    logic sdio_s;
`ifdef AD9866_RESP_READBACK_EN
    logic sclk_fall;
`endif

    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (spi_sclk),
        .sen_n     (spi_sen_n),
        .sdio      (spi_sdio),
        .sclk_rise (sclk_rise),
`ifdef AD9866_RESP_READBACK_EN
        .sclk_fall (sclk_fall),
`else
        .sclk_fall (),
`endif
        .sen_n_s   (sen_n_s),
        .sen_rise  (sen_rise),
        .sen_fall  (sen_fall),
        .sdio_s    (sdio_s)
    );

    resp_state_t                  state;
    logic [AD9866_FRAME_BITS-1:0] shreg;
    logic [AD9866_FRAME_BITS-1:0] shreg_nxt;
    logic [4:0]                   bit_cnt;
    logic                         extra_seen;
    logic [7:0]                   regs [NUM_REGS];
    frame_t                       frame;

    assign shreg_nxt = {shreg[AD9866_FRAME_BITS-2:0], sdio_s};
    assign frame     = shreg;

    function automatic logic addr_ok(input logic [4:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            extra_seen <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_err  <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i[4:0]] <= ad9866_rst_val(i);
            end
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                // Only start decoding once the bus is seen idle, so a reset
                // released mid-frame drops the tail of that frame.
                WAIT_IDLE: begin
                    if (sen_n_s) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (sen_fall) begin
                        shreg      <= '0;
                        bit_cnt    <= '0;
                        extra_seen <= 1'b0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sen_rise) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else if (sclk_rise) begin
                        shreg   <= shreg_nxt;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'(AD9866_FRAME_BITS - 1)) begin
                            state <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    if (frame.byte_cnt != 2'b00) begin
                        frame_err <= 1'b1;
                    end else if (!frame.rw && addr_ok(frame.addr)) begin
                        regs[frame.addr] <= frame.data;
                        wr_addr          <= frame.addr;
                        wr_data          <= frame.data;
                        wr_strobe        <= 1'b1;
                    end
                    state <= DONE;
                end
                DONE: begin
                    // Level check: sen_n may already have risen during COMMIT.
                    if (sen_n_s) begin
                        state <= IDLE;
                    end else if (sclk_rise && !extra_seen) begin
                        frame_err  <= 1'b1;
                        extra_seen <= 1'b1;
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

`ifdef AD9866_RESP_READBACK_EN
    logic [7:0] sdo_shift;
    logic       sdo_q;

    // The shifter stays zero until a read address is known, so falling edges
    // before the load simply keep driving 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdo_shift <= '0;
            sdo_q     <= 1'b0;
        end else if (sen_n_s) begin
            sdo_shift <= '0;
            sdo_q     <= 1'b0;
        end else if (state == SHIFT && sclk_rise && !sen_rise &&
                     bit_cnt == 5'd7 && shreg_nxt[7]) begin
            sdo_shift <= addr_ok(shreg_nxt[4:0]) ? regs[shreg_nxt[4:0]] : 8'h00;
        end else if (sclk_fall) begin
            sdo_q     <= sdo_shift[7];
            sdo_shift <= {sdo_shift[6:0], 1'b0};
        end
    end

    assign spi_sdo = sdo_q;
`else
    assign spi_sdo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_data <= '0;
        end else begin
            host_data <= addr_ok(host_addr) ? regs[host_addr] : 8'h00;
        end
    end

    assign tx_gain = regs[AD9866_REG_TXGAIN][3:0];
    assign rx_gain = regs[AD9866_REG_RXGAIN][5:0];

endmodule

// File: tb/tb_ad9866_spi_responder.sv
// Directed bench for ad9866_spi_responder: one instance at SYNC_STAGES=0
// (sclk = clk/2) and one at SYNC_STAGES=2 (sclk = clk/8), separate SPI buses.
// Build option: AD9866_RESP_READBACK_EN selects the expected spi_sdo data.
module tb_ad9866_spi_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       sclk0, sen0, sdio0, sclk2, sen2, sdio2;
    logic [4:0] haddr0, haddr2;
    logic       spi_sdo0, wr_strobe0, frame_err0;
    logic       spi_sdo2, wr_strobe2, frame_err2;
    logic [4:0] wr_addr0, wr_addr2;
    logic [7:0] wr_data0, wr_data2, host_data0, host_data2;
    logic [3:0] tx_gain0, tx_gain2;
    logic [5:0] rx_gain0, rx_gain2;

    ad9866_spi_responder #(.SYNC_STAGES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .spi_sclk(sclk0), .spi_sen_n(sen0), .spi_sdio(sdio0),
        .spi_sdo(spi_sdo0), .wr_strobe(wr_strobe0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .tx_gain(tx_gain0), .rx_gain(rx_gain0), .frame_err(frame_err0),
        .host_addr(haddr0), .host_data(host_data0)
    );

    ad9866_spi_responder #(.SYNC_STAGES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .spi_sclk(sclk2), .spi_sen_n(sen2), .spi_sdio(sdio2),
        .spi_sdo(spi_sdo2), .wr_strobe(wr_strobe2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .tx_gain(tx_gain2), .rx_gain(rx_gain2), .frame_err(frame_err2),
        .host_addr(haddr2), .host_data(host_data2)
    );

`ifdef AD9866_RESP_READBACK_EN
    localparam logic [15:0] RD_EXP  = 16'h0080;
    localparam logic        SDO_MSB = 1'b1;
`else
    localparam logic [15:0] RD_EXP  = 16'h0000;
    localparam logic        SDO_MSB = 1'b0;
`endif

    int n_vec = 0;
    int n_bad = 0;

    // Pulse counters and the host_data view around a dut2 write commit.
    int         n_str0 = 0, n_err0 = 0, n_str2 = 0, n_err2 = 0;
    logic [7:0] hd_at_str2 = 8'h00, hd_after_str2 = 8'h00;
    logic       str2_d = 1'b0;

    always @(negedge clk) begin
        if (wr_strobe0) n_str0++;
        if (frame_err0) n_err0++;
        if (wr_strobe2) n_str2++;
        if (frame_err2) n_err2++;
        if (str2_d) hd_after_str2 = host_data2;
        str2_d = wr_strobe2;
        if (wr_strobe2) hd_at_str2 = host_data2;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic sen, input logic sck, input logic sd);
        if (sel == 0) begin
            sen0 = sen; sclk0 = sck; sdio0 = sd;
        end else begin
            sen2 = sen; sclk2 = sck; sdio2 = sd;
        end
    endtask

    // Shifts bits [first, first+nbits) of word (bits past 15 are zero); sdo is
    // sampled at the end of each low phase, just before the next rising edge.
    task automatic spi_bits(input int sel, input logic [15:0] word, input int first,
                            input int nbits, input int half, input bit lower,
                            input bit raise, output logic [15:0] rd);
        logic b;
        b  = 1'b0;
        rd = '0;
        if (lower) begin
            drive(sel, 1'b0, 1'b0, 1'b0);
            repeat (half) begin @(posedge clk); #1; end
        end
        for (int i = first; i < first + nbits; i++) begin
            b = (i < 16) ? word[15-i] : 1'b0;
            drive(sel, 1'b0, 1'b0, b);
            for (int k = 0; k < half; k++) begin
                @(negedge clk);
                if (k == half - 1 && i < 16) rd[15-i] = (sel == 0) ? spi_sdo0 : spi_sdo2;
                @(posedge clk); #1;
            end
            drive(sel, 1'b0, 1'b1, b);
            repeat (half) begin @(posedge clk); #1; end
        end
        drive(sel, 1'b0, 1'b0, b);
        repeat (half) begin @(posedge clk); #1; end
        if (raise) begin
            drive(sel, 1'b1, 1'b0, 1'b0);
            repeat (12) begin @(posedge clk); #1; end
        end
    endtask

    typedef struct {
        int          sel;
        logic [15:0] word;
        int          nbits;
        logic [4:0]  haddr;
        int          exp_str;
        int          exp_err;
        logic [4:0]  exp_wa;
        logic [7:0]  exp_wd;
        logic [7:0]  exp_hd;
        logic [3:0]  exp_tx;
        logic [5:0]  exp_rx;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [15:0] rd;
        int          s0, e0, half;
        logic [4:0]  wa;
        logic [7:0]  wd, hd;
        logic [3:0]  tx;
        logic [5:0]  rx;

        //           sel word      bits haddr str err wa     wd     hd     tx    rx     rd
        vecs[0] = '{0, 16'h0a07, 16, 5'h0a, 1, 0, 5'h0a, 8'h07, 8'h07, 4'h7, 6'h00, 16'h0000};
        vecs[1] = '{2, 16'h0965, 16, 5'h09, 1, 0, 5'h09, 8'h65, 8'h65, 4'h0, 6'h25, 16'h0000};
        vecs[2] = '{2, 16'h0477, 10, 5'h04, 0, 1, 5'h09, 8'h65, 8'h00, 4'h0, 6'h25, 16'h0000};
        vecs[3] = '{2, 16'h0436, 16, 5'h04, 1, 0, 5'h04, 8'h36, 8'h36, 4'h0, 6'h25, 16'h0000};
        vecs[4] = '{2, 16'h2455, 16, 5'h04, 0, 1, 5'h04, 8'h36, 8'h36, 4'h0, 6'h25, 16'h0000};
        vecs[5] = '{2, 16'h15ab, 16, 5'h15, 0, 0, 5'h04, 8'h36, 8'h00, 4'h0, 6'h25, 16'h0000};
        vecs[6] = '{2, 16'h0311, 17, 5'h03, 1, 1, 5'h03, 8'h11, 8'h11, 4'h0, 6'h25, 16'h0000};
        vecs[7] = '{2, 16'h8000, 16, 5'h00, 0, 0, 5'h03, 8'h11, 8'h80, 4'h0, 6'h25, RD_EXP};

        rst_n = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0);
        drive(2, 1'b1, 1'b0, 1'b0);
        haddr0 = 5'h00;
        haddr2 = 5'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_strobe", 32'(wr_strobe2), 32'h0);
        check("rst_frame_err", 32'(frame_err2), 32'h0);
        check("rst_wr_addr",   32'(wr_addr2),   32'h0);
        check("rst_wr_data",   32'(wr_data2),   32'h0);
        check("rst_host_data", 32'(host_data2), 32'h0);
        check("rst_spi_sdo",   32'(spi_sdo2),   32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        @(negedge clk);
        check("rst_reg00", 32'(host_data2), 32'h80);
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            half = (vecs[v].sel == 0) ? 1 : 4;
            if (vecs[v].sel == 0) begin
                haddr0 = vecs[v].haddr; s0 = n_str0; e0 = n_err0;
            end else begin
                haddr2 = vecs[v].haddr; s0 = n_str2; e0 = n_err2;
            end
            spi_bits(vecs[v].sel, vecs[v].word, 0, vecs[v].nbits, half, 1'b1, 1'b1, rd);
            repeat (4) @(posedge clk);
            @(negedge clk);
            if (vecs[v].sel == 0) begin
                s0 = n_str0 - s0; e0 = n_err0 - e0;
                {wa, wd, hd, tx, rx} = {wr_addr0, wr_data0, host_data0, tx_gain0, rx_gain0};
            end else begin
                s0 = n_str2 - s0; e0 = n_err2 - e0;
                {wa, wd, hd, tx, rx} = {wr_addr2, wr_data2, host_data2, tx_gain2, rx_gain2};
            end
            check($sformatf("v%0d_strobes", v),   32'(s0), 32'(vecs[v].exp_str));
            check($sformatf("v%0d_frame_err", v), 32'(e0), 32'(vecs[v].exp_err));
            check($sformatf("v%0d_wr_addr", v),   32'(wa), 32'(vecs[v].exp_wa));
            check($sformatf("v%0d_wr_data", v),   32'(wd), 32'(vecs[v].exp_wd));
            check($sformatf("v%0d_host_data", v), 32'(hd), 32'(vecs[v].exp_hd));
            check($sformatf("v%0d_tx_gain", v),   32'(tx), 32'(vecs[v].exp_tx));
            check($sformatf("v%0d_rx_gain", v),   32'(rx), 32'(vecs[v].exp_rx));
            check($sformatf("v%0d_sdo_bits", v),  32'(rd), 32'(vecs[v].exp_rd));
            if (v == 1) begin
                check("race_old_value", 32'(hd_at_str2),    32'h00);
                check("race_new_value", 32'(hd_after_str2), 32'h65);
            end
            @(posedge clk); #1;
        end

        // Read frame cut after 8 edges: MSB appears, then sen_n high clears sdo.
        s0 = n_str2; e0 = n_err2;
        spi_bits(2, 16'h8000, 0, 8, 4, 1'b1, 1'b0, rd);
        @(negedge clk);
        check("abort_sdo_msb", 32'(spi_sdo2), 32'(SDO_MSB));
        @(posedge clk); #1;
        drive(2, 1'b1, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("abort_sdo_idle",  32'(spi_sdo2),    32'h0);
        check("abort_frame_err", 32'(n_err2 - e0), 32'h1);
        check("abort_strobes",   32'(n_str2 - s0), 32'h0);
        @(posedge clk); #1;

        // Reset pulsed mid-frame, then the frame tail, then a good frame.
        haddr2 = 5'h00;
        spi_bits(2, 16'h0722, 0, 6, 4, 1'b1, 1'b0, rd);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_rst_wr_addr",   32'(wr_addr2),   32'h0);
        check("mid_rst_wr_data",   32'(wr_data2),   32'h0);
        check("mid_rst_host_data", 32'(host_data2), 32'h0);
        check("mid_rst_rx_gain",   32'(rx_gain2),   32'h0);
        check("mid_rst_tx_gain0",  32'(tx_gain0),   32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        s0 = n_str2; e0 = n_err2;
        spi_bits(2, 16'h0722, 6, 10, 4, 1'b0, 1'b1, rd);
        @(negedge clk);
        check("tail_strobes",   32'(n_str2 - s0), 32'h0);
        check("tail_frame_err", 32'(n_err2 - e0), 32'h0);
        check("tail_reg00",     32'(host_data2),  32'h80);
        @(posedge clk); #1;
        haddr2 = 5'h07;
        s0 = n_str2;
        spi_bits(2, 16'h0722, 0, 16, 4, 1'b1, 1'b1, rd);
        @(negedge clk);
        check("post_rst_strobes",   32'(n_str2 - s0), 32'h1);
        check("post_rst_wr_addr",   32'(wr_addr2),    32'h07);
        check("post_rst_wr_data",   32'(wr_data2),    32'h22);
        check("post_rst_host_data", 32'(host_data2),  32'h22);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ad9866_spi_responder.md
Name: ad9866_spi_responder

Overview:
- SPI responder that models the AD9866 serial-control slave: the receiving end of the 16-bit SPI write/read frames produced by the AD9866 control master.
- Oversamples sclk/sen_n/sdio in the system clock. Decodes R/W, byte count, 5-bit address and 8-bit data. Maintains the 20-entry register file (0x00–0x13) and exposes decoded TX/RX gain plus a write strobe.
- Used as a loopback target in the board-level sim/bring-up build, and as a shadow register monitor.

Parameters:
- SYNC_STAGES, 2, number of input synchronizer flops on sclk/sen_n/sdio. 0 is legal for same-clock-domain masters (sclk = clk/2).
- NUM_REGS, 20, register-file depth. Valid addresses are 0 .. NUM_REGS-1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- spi_sclk  input  1  SPI clock from master, idle low
- spi_sen_n  input  1  SPI enable, active low
- spi_sdio  input  1  serial data in, MSB first
- spi_sdo  output  1  serial readback data (4-wire mode)
- wr_strobe  output  1  one-cycle pulse on committed register write
- wr_addr  output  5  address of last committed write
- wr_data  output  8  data of last committed write
- tx_gain  output  4  reg 0x0a[3:0]
- rx_gain  output  6  reg 0x09[5:0]
- frame_err  output  1  one-cycle pulse on malformed frame
- host_addr  input  5  local register read address
- host_data  output  8  register contents, 1-cycle registered latency

Behaviour:
- Reset values: all registers 0x00 except reg 0x00 = 0x80 (4-wire). spi_sdo=0, wr_strobe=0, wr_addr=0, wr_data=0, frame_err=0, host_data=0, state WAIT_IDLE.
- Edge detect: synchronized sclk is registered once more. A rising edge is sampled when the previous value is 0 and the current value is 1; a falling edge is the reverse.
  - SYNC_STAGES=0 must work with sclk high 1 clk / low 1 clk.
  - SYNC_STAGES≥1 requires sclk high and low ≥ SYNC_STAGES+1 clk each.
- Frame format: bit15 R/W (1=read), bits14:13 byte count (must be 00), bits12:8 address, bits7:0 data. 16 rising edges per frame; bits are sampled on the rising edge.
- States:
  - WAIT_IDLE: wait for synchronized sen_n=1, then go to IDLE. Entered after reset, so a reset released mid-frame ignores the rest of that frame.
  - IDLE: on sen_n falling, clear shift register and bit counter, go to SHIFT.
  - SHIFT: shift spi_sdio in on each rising sclk.
    - On sen_n rising with count<16: frame_err pulse, no write, go to IDLE.
    - At the 16th edge: go to COMMIT.
  - COMMIT: one clk. For a write with count=00 and addr<NUM_REGS: update the register, set wr_addr/wr_data, pulse wr_strobe. Byte count≠00: frame_err pulse, no write. Addr≥NUM_REGS write: silently ignored, no strobe. Then go to DONE.
  - DONE: extra rising sclk edges before sen_n rises: frame_err pulse (once per frame), register not re-written. On sen_n rising, go to IDLE.
- Readback (see Optional Feature):
  - After the 8th rising edge of a read frame, load the register (0x00 if addr out of range) into the output shifter.
  - Drive spi_sdo with the MSB on the next falling sclk edge. Shift on each subsequent falling edge.
  - spi_sdo returns to 0 when sen_n=1.
  - Read frames never write and never pulse wr_strobe.
- tx_gain/rx_gain are continuous views of the register file; they update the cycle after COMMIT.
- host_data <= reg[host_addr] every clk; returns 0x00 for out-of-range addresses.
- Simultaneous local read and SPI write to the same address: host_data shows the old value that cycle and the new value the next cycle.

Optional Feature:
- Macro: AD9866_RESP_READBACK_EN.
- Defined: the read path is implemented as above.
- Undefined: spi_sdo is tied 0. Read frames are fully shifted and then dropped without error. The output shifter logic is omitted.

Decomposition:
- Shared package ad9866_pkg:
  - AD9866_FRAME_BITS=16.
  - Address constants AD9866_REG_RXGAIN=5'h09, AD9866_REG_TXGAIN=5'h0a.
  - Reset-value array.
  - typedef enum resp_state_t {WAIT_IDLE, IDLE, SHIFT, COMMIT, DONE}.
- One sub-module: spi_edge_sync (parameterized synchronizer plus rise/fall detection for sclk/sen_n/sdio).

Test Plan:
- Write 0x0a=0x07, SYNC_STAGES=0, sclk=clk/2 -> wr_strobe 1 clk, wr_addr=0x0a, wr_data=0x07, tx_gain=4'h7.
- Write 0x09=0x65 with SYNC_STAGES=2, sclk=clk/8 -> rx_gain=6'h25, host_addr=0x09 gives host_data=0x65 one clk later.
- sen_n raised after 10 edges -> frame_err pulse, no wr_strobe, registers unchanged; the next valid frame (write 0x04=0x36) commits normally.
- Write frame with byte count=01 to addr 0x04, then a write to addr 0x15 -> first: frame_err, no strobe; second: no strobe, no error, host read of 0x15 = 0x00.
- rst_n pulsed low mid-frame -> all outputs at reset values; remainder of that frame ignored; the following frame commits.
- With AD9866_RESP_READBACK_EN: read frame 0x8000 after reset -> spi_sdo shifts 1,0,0,0,0,0,0,0 (0x80). Without it: spi_sdo stays 0 and there is no strobe.
